pc_ad_bus_master: RTL

- Initiator end of the multiplexed 8088-style local bus; converts single-beat read/write requests into T1–T4 bus cycles.
- Drives low address on AD[7:0] with an ALE strobe in T1 for the downstream transparent address latches, then carries data on the same pins.
- Inserts wait states from READY; returns read data and completion on a response pulse.
- Sits between the CPU-core model and the board-level latches and transceivers.

---
 rtl/pc_bus_pkg.sv | 21 ++
 rtl/pc_ad_bus_master.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pc_bus_pkg.sv
// rtl/pc_bus_pkg.sv - shared types and constants for the 8088-style multiplexed bus
package pc_bus_pkg;

  localparam int AD_W   = 8;
  localparam int ADDR_W = 20;

  localparam logic CYC_MEM = 1'b0;
  localparam logic CYC_IO  = 1'b1;
  localparam logic CYC_RD  = 1'b0;
  localparam logic CYC_WR  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_TW,
    ST_T4
  } bus_state_e;

endpackage

// File: rtl/pc_ad_bus_master.sv
// rtl/pc_ad_bus_master.sv - single-beat request to T1-T4 multiplexed bus cycle initiator
module pc_ad_bus_master
  import pc_bus_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic                   req_io,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [AD_W-1:0]        req_wdata,
  output logic                   rsp_valid,
  output logic [AD_W-1:0]        rsp_rdata,
  output logic                   rsp_err,
  output logic [AD_W-1:0]        ad_out,
  output logic                   ad_oe,
  input  logic [AD_W-1:0]        ad_in,
  output logic [ADDR_W-AD_W-1:0] a_hi,
  output logic                   ale,
  output logic                   rd_n,
  output logic                   wr_n,
  output logic                   iom,
  output logic                   den_n,
  output logic                   dt_r,
  input  logic                   ready
);

  bus_state_e      state;
  logic            wr_q;
  logic [AD_W-1:0] wdata_q;
  logic [7:0]      wait_cnt;
  logic            accept;
  logic            wait_abort;

  // wait_cnt counts TW cycles already spent, so the limit trips after exactly WAIT_LIMIT of them
  always_comb begin
    accept     = req_valid && req_ready;
    wait_abort = (WAIT_LIMIT != 0) && (int'(wait_cnt) >= WAIT_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      ad_out    <= '0;
      ad_oe     <= 1'b0;
      a_hi      <= '0;
      ale       <= 1'b0;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      iom       <= CYC_MEM;
      den_n     <= 1'b1;
      dt_r      <= CYC_RD;
      wr_q      <= CYC_RD;
      wdata_q   <= '0;
      wait_cnt  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE, ST_T4: begin
          ad_oe <= 1'b0;
          rd_n  <= 1'b1;
          wr_n  <= 1'b1;
          den_n <= 1'b1;
          if (accept) begin
            state     <= ST_T1;
            req_ready <= 1'b0;
            ale       <= 1'b1;
            ad_out    <= req_addr[AD_W-1:0];
            ad_oe     <= 1'b1;
            a_hi      <= req_addr[ADDR_W-1:AD_W];
            iom       <= (req_io == CYC_IO);
            dt_r      <= (req_write == CYC_WR);
            wr_q      <= req_write;
            wdata_q   <= req_wdata;
            wait_cnt  <= '0;
          end else begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        ST_T1: begin
          state <= ST_T2;
          ale   <= 1'b0;
          den_n <= 1'b0;
          if (wr_q == CYC_WR) begin
            ad_out <= wdata_q;
            ad_oe  <= 1'b1;
            wr_n   <= 1'b0;
          end else begin
            ad_oe  <= 1'b0;
            rd_n   <= 1'b0;
          end
        end
        ST_T2: state <= ST_T3;
        ST_T3, ST_TW: begin
          if (ready || wait_abort) begin
            state     <= ST_T4;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= !ready;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            den_n     <= 1'b1;
            ad_oe     <= 1'b0;
            if (!ready) rsp_rdata <= '0;
            else if (wr_q == CYC_RD) rsp_rdata <= ad_in;
          end else begin
            state <= ST_TW;
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
